dm_handover_responder: RTL and testbench

- Mobile-device (DM) end of the base-station handover protocol; answers request/respond traffic from base stations BS1..BS3.
- Tracks the serving BS and broadcasts the serving link quality.
- On a request from the serving BS, compares per-BS quality measurements and returns the best target index.
- Supervises the handover until the new BS asserts respond, and forwards downlink data from whichever BS is serving.

---
 rtl/dm_handover_responder_if.sv | 32 +++
 rtl/dm_handover_responder.sv | 155 +++++++++++++++
 tb/tb_dm_handover_responder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_handover_responder_if.sv
// Bundle between the base stations (master) and the mobile-device responder (slave).
// Carries quality measurements, request/respond handshakes, downlink data and DM answers.
interface dm_handover_responder_if #(
    parameter int SQ_W   = 8,
    parameter int DATA_W = 8
);
    logic [SQ_W-1:0]       sq_bs1;
    logic [SQ_W-1:0]       sq_bs2;
    logic [SQ_W-1:0]       sq_bs3;
    logic                  sq_valid;
    logic [2:0]            bs_request;
    logic [2:0]            bs_respond;
    logic [3*DATA_W-1:0]   bs_data;

    logic [SQ_W-1:0]       dm_sq;
    logic [1:0]            dm_target;
    logic                  dm_target_valid;
    logic [1:0]            serving;
    logic [DATA_W-1:0]     dm_data;
    logic                  dm_data_valid;
    logic                  ho_fail;

    modport master (
        output sq_bs1, sq_bs2, sq_bs3, sq_valid, bs_request, bs_respond, bs_data,
        input  dm_sq, dm_target, dm_target_valid, serving, dm_data, dm_data_valid, ho_fail
    );

    modport slave (
        input  sq_bs1, sq_bs2, sq_bs3, sq_valid, bs_request, bs_respond, bs_data,
        output dm_sq, dm_target, dm_target_valid, serving, dm_data, dm_data_valid, ho_fail
    );
endinterface

// File: rtl/dm_handover_responder.sv
// DM-side handover responder: tracks serving BS, picks handover target, forwards downlink data.
// Target answer 2 cycles after request; BS side waits while dm_target = 3. Stats under HO_STATS_EN.
module dm_handover_responder #(
    parameter int SQ_W       = 8,
    parameter int DATA_W     = 8,
    parameter int HYST       = 8,
    parameter int HO_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    dm_handover_responder_if.slave bus
`ifdef HO_STATS_EN
    ,
    output logic [15:0] ho_count,
    output logic [15:0] ho_fail_count
`endif
);
    localparam int             CNT_W  = $clog2(HO_TIMEOUT + 1);
    localparam logic [1:0]     NONE   = 2'd3;
    localparam logic [SQ_W:0]  HYST_X = (SQ_W+1)'(HYST);

    typedef enum logic [2:0] {SEARCH, ATTACHED, EVALUATE, ANSWER, HANDOVER} state_t;

    state_t                  state;
    logic [2:0][SQ_W-1:0]    sq_r;
    logic [2:0][SQ_W-1:0]    sq_nxt;
    logic [3:0][SQ_W-1:0]    sq_r4;
    logic [3:0][SQ_W-1:0]    sq_n4;
    logic [3:0][DATA_W-1:0]  data4;
    logic [3:0]              resp4;
    logic [3:0]              req4;
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              first_resp;
    logic [1:0]              cand_a;
    logic [1:0]              cand_b;
    logic [1:0]              cand;
    logic [1:0]              eval_target;
    logic [1:0]              serving_nxt;
    logic                    better;
    logic                    drop;
    logic                    ho_ok;
    logic                    ho_to;

    // Index 3 (NONE) maps to zero quality / zero data / no handshake.
    assign sq_nxt     = bus.sq_valid ? {bus.sq_bs3, bus.sq_bs2, bus.sq_bs1} : sq_r;
    assign sq_r4      = {{SQ_W{1'b0}}, sq_r};
    assign sq_n4      = {{SQ_W{1'b0}}, sq_nxt};
    assign data4      = {{DATA_W{1'b0}}, bus.bs_data};
    assign resp4      = {1'b0, bus.bs_respond};
    assign req4       = {1'b0, bus.bs_request};
    assign first_resp = bus.bs_respond[0] ? 2'd0 : (bus.bs_respond[1] ? 2'd1 : 2'd2);

    always_comb begin
        cand_a = 2'd0;
        cand_b = 2'd1;
        case (bus.serving)
            2'd0:    begin cand_a = 2'd1; cand_b = 2'd2; end
            2'd1:    begin cand_a = 2'd0; cand_b = 2'd2; end
            default: ;
        endcase
    end

    // cand_a < cand_b, so strict compare hands ties to the lower index.
    assign cand        = (sq_r4[cand_b] > sq_r4[cand_a]) ? cand_b : cand_a;
    assign better      = {1'b0, sq_r4[cand]} > ({1'b0, sq_r4[bus.serving]} + HYST_X);
    assign eval_target = better ? cand : bus.serving;

    assign drop  = (state == ATTACHED) && !resp4[bus.serving];
    assign ho_ok = (state == HANDOVER) && resp4[bus.dm_target];
    assign ho_to = (state == HANDOVER) && !ho_ok && (cnt <= CNT_W'(1));

    always_comb begin
        serving_nxt = bus.serving;
        if ((state == SEARCH) && (|bus.bs_respond)) serving_nxt = first_resp;
        else if (drop)                              serving_nxt = NONE;
        else if (ho_ok)                             serving_nxt = bus.dm_target;
        else if (ho_to && !resp4[bus.serving])      serving_nxt = NONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= SEARCH;
            sq_r                <= '0;
            cnt                 <= '0;
            bus.serving         <= NONE;
            bus.dm_sq           <= '0;
            bus.dm_target       <= NONE;
            bus.dm_target_valid <= 1'b0;
            bus.dm_data         <= '0;
            bus.dm_data_valid   <= 1'b0;
            bus.ho_fail         <= 1'b0;
`ifdef HO_STATS_EN
            ho_count            <= '0;
            ho_fail_count       <= '0;
`endif
        end else begin
            sq_r        <= sq_nxt;
            bus.serving <= serving_nxt;
            bus.dm_sq   <= sq_n4[serving_nxt];
            bus.ho_fail <= 1'b0;
            // Keyed on the next serving index so a new BS's data lands the cycle it takes over.
            if ((serving_nxt != NONE) && resp4[serving_nxt]) begin
                bus.dm_data       <= data4[serving_nxt];
                bus.dm_data_valid <= 1'b1;
            end else begin
                bus.dm_data_valid <= 1'b0;
            end

            case (state)
                SEARCH: if (|bus.bs_respond) state <= ATTACHED;
                ATTACHED: begin
                    if (drop)                       state <= SEARCH;
                    else if (req4[bus.serving])     state <= EVALUATE;
                end
                EVALUATE: begin
                    bus.dm_target       <= eval_target;
                    bus.dm_target_valid <= 1'b1;
                    state               <= ANSWER;
                end
                ANSWER: begin
                    if (!req4[bus.serving]) begin
                        bus.dm_target_valid <= 1'b0;
                        if (bus.dm_target == bus.serving) begin
                            bus.dm_target <= NONE;
                            state         <= ATTACHED;
                        end else begin
                            cnt   <= CNT_W'(HO_TIMEOUT);
                            state <= HANDOVER;
                        end
                    end
                end
                HANDOVER: begin
                    if (ho_ok) begin
                        bus.dm_target <= NONE;
                        state         <= ATTACHED;
`ifdef HO_STATS_EN
                        if (ho_count != 16'hFFFF) ho_count <= ho_count + 16'd1;
`endif
                    end else if (ho_to) begin
                        bus.ho_fail   <= 1'b1;
                        bus.dm_target <= NONE;
                        cnt           <= '0;
                        state         <= resp4[bus.serving] ? ATTACHED : SEARCH;
`ifdef HO_STATS_EN
                        if (ho_fail_count != 16'hFFFF) ho_fail_count <= ho_fail_count + 16'd1;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_handover_responder.sv
// Directed + randomized bench for dm_handover_responder against a rule-level reference model.
module tb_dm_handover_responder;
    localparam int SQ_W = 8, DATA_W = 8, HYST = 8, HO_TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dm_handover_responder_if #(.SQ_W(SQ_W), .DATA_W(DATA_W)) bus ();
`ifdef HO_STATS_EN
    logic [15:0] ho_count, ho_fail_count;
`endif

    dm_handover_responder #(.SQ_W(SQ_W), .DATA_W(DATA_W), .HYST(HYST), .HO_TIMEOUT(HO_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef HO_STATS_EN
        ,
        .ho_count      (ho_count),
        .ho_fail_count (ho_fail_count)
`endif
    );

    int vectors = 0, miscompares = 0;
    int m_sq [3];
    int m_serving;
    int m_ok, m_fail;
    logic [3*DATA_W-1:0] last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        last_data = bus.bs_data;
        @(posedge clk);
        #1;
        bus.bs_data = (3*DATA_W)'($urandom);
    endtask

    function automatic int slice_of(input logic [3*DATA_W-1:0] d, input int k);
        return int'(d[k*DATA_W +: DATA_W]);
    endfunction

    function automatic int lowest(input logic [2:0] r);
        for (int k = 0; k < 3; k++) if (r[k]) return k;
        return 3;
    endfunction

    // Best other BS by quality (first max wins ties), must beat serving by more than HYST.
    function automatic int expect_target(input int s);
        int c = -1;
        for (int k = 0; k < 3; k++)
            if (k != s && (c < 0 || m_sq[k] > m_sq[c])) c = k;
        return (m_sq[c] > m_sq[s] + HYST) ? c : s;
    endfunction

    task automatic load_sq(input int a, input int b, input int c);
        bus.sq_bs1 = SQ_W'(a); bus.sq_bs2 = SQ_W'(b); bus.sq_bs3 = SQ_W'(c);
        bus.sq_valid = 1'b1;
        tick();
        bus.sq_valid = 1'b0;
        m_sq[0] = a; m_sq[1] = b; m_sq[2] = c;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_dm_sq"}, 32'(bus.dm_sq), 0);
        chk({tag, "_target"}, 32'(bus.dm_target), 3);
        chk({tag, "_target_valid"}, 32'(bus.dm_target_valid), 0);
        chk({tag, "_serving"}, 32'(bus.serving), 3);
        chk({tag, "_dm_data"}, 32'(bus.dm_data), 0);
        chk({tag, "_data_valid"}, 32'(bus.dm_data_valid), 0);
        chk({tag, "_ho_fail"}, 32'(bus.ho_fail), 0);
`ifdef HO_STATS_EN
        chk({tag, "_ho_count"}, 32'(ho_count), 0);
        chk({tag, "_ho_fail_count"}, 32'(ho_fail_count), 0);
`endif
    endtask

    task automatic check_attached(input string tag);
        tick();
        chk({tag, "_serving"}, 32'(bus.serving), m_serving);
        chk({tag, "_dm_sq"}, 32'(bus.dm_sq), m_sq[m_serving]);
        chk({tag, "_dm_data"}, 32'(bus.dm_data), slice_of(last_data, m_serving));
        chk({tag, "_data_valid"}, 32'(bus.dm_data_valid), 1);
        chk({tag, "_target_idle"}, 32'(bus.dm_target), 3);
    endtask

    // mode 0: new BS responds; mode 1: timeout, old BS still up; mode 2: timeout, old BS gone.
    task automatic ho_round(input string tag, input int a, input int b, input int c,
                            input int mode, input bit sq_glitch);
        int s, exp_t, n;
        logic [2:0] r;
        load_sq(a, b, c);
        s = m_serving;
        exp_t = expect_target(s);
        bus.bs_request = 3'(1 << s);
        tick();
        chk({tag, "_valid_early"}, 32'(bus.dm_target_valid), 0);
        if (sq_glitch) begin
            bus.sq_bs1 = SQ_W'($urandom); bus.sq_bs2 = SQ_W'($urandom); bus.sq_bs3 = SQ_W'($urandom);
            bus.sq_valid = 1'b1;
            tick();
            bus.sq_valid = 1'b0;
            m_sq[0] = int'(bus.sq_bs1); m_sq[1] = int'(bus.sq_bs2); m_sq[2] = int'(bus.sq_bs3);
        end else begin
            tick();
        end
        chk({tag, "_target_valid"}, 32'(bus.dm_target_valid), 1);
        chk({tag, "_target"}, 32'(bus.dm_target), exp_t);
        tick();
        chk({tag, "_target_hold"}, 32'(bus.dm_target), exp_t);
        bus.bs_request = 3'b000;
        tick();
        chk({tag, "_valid_clr"}, 32'(bus.dm_target_valid), 0);
        if (exp_t == s) begin
            chk({tag, "_stay_target"}, 32'(bus.dm_target), 3);
            chk({tag, "_stay_serving"}, 32'(bus.serving), s);
        end else if (mode == 0) begin
            n = $urandom_range(0, 5);
            repeat (n) tick();
            bus.bs_respond = 3'(1 << exp_t);
            tick();
            m_serving = exp_t;
            m_ok++;
            chk({tag, "_ho_serving"}, 32'(bus.serving), exp_t);
            chk({tag, "_ho_target"}, 32'(bus.dm_target), 3);
            chk({tag, "_ho_data"}, 32'(bus.dm_data), slice_of(last_data, exp_t));
            chk({tag, "_ho_data_valid"}, 32'(bus.dm_data_valid), 1);
        end else begin
            bus.bs_respond = (mode == 1) ? 3'(1 << s) : 3'b000;
            repeat (HO_TIMEOUT - 1) tick();
            chk({tag, "_fail_early"}, 32'(bus.ho_fail), 0);
            tick();
            chk({tag, "_fail_pulse"}, 32'(bus.ho_fail), 1);
            chk({tag, "_fail_target"}, 32'(bus.dm_target), 3);
            m_serving = (mode == 1) ? s : 3;
            m_fail++;
            chk({tag, "_fail_serving"}, 32'(bus.serving), m_serving);
            tick();
            chk({tag, "_fail_one_cycle"}, 32'(bus.ho_fail), 0);
            if (mode == 2) begin
                r = 3'($urandom_range(1, 7));
                bus.bs_respond = r;
                tick();
                m_serving = lowest(r);
                chk({tag, "_reattach"}, 32'(bus.serving), m_serving);
            end
        end
        bus.bs_respond = 3'(1 << m_serving);
        check_attached({tag, "_after"});
    endtask

    initial begin
        int rs;
        reset = 1'b1;
        bus.sq_bs1 = '0; bus.sq_bs2 = '0; bus.sq_bs3 = '0; bus.sq_valid = 1'b0;
        bus.bs_request = '0; bus.bs_respond = '0;
        bus.bs_data = (3*DATA_W)'($urandom);
        m_sq = '{0, 0, 0}; m_serving = 3; m_ok = 0; m_fail = 0;
        #12;
        check_reset("reset");
        tick();
        reset = 1'b0;
        tick();
        chk("search_idle_serving", 32'(bus.serving), 3);

        // Attach to BS2 with a quality pulse on the same cycle.
        bus.bs_respond = 3'b010;
        bus.sq_bs1 = 0; bus.sq_bs2 = 80; bus.sq_bs3 = 0; bus.sq_valid = 1'b1;
        tick();
        bus.sq_valid = 1'b0;
        m_sq = '{0, 80, 0};
        m_serving = 1;
        chk("attach_serving", 32'(bus.serving), 1);
        check_attached("attach_bs2");

        ho_round("ho_to_bs1", 70, 40, 60, 0, 1'b0);
        ho_round("stay_hyst", 60, 65, 50, 0, 1'b0);
        ho_round("timeout_keep", 20, 30, 90, 1, 1'b0);
        ho_round("timeout_drop", 20, 30, 90, 2, 1'b0);
        if (m_serving != 1) begin
            bus.bs_respond = 3'b000; tick(); tick();
            bus.bs_respond = 3'b010; tick(); m_serving = 1;
            check_attached("reattach_bs2");
        end
        ho_round("tie_low", 90, 10, 90, 0, 1'b0);
        ho_round("no_wrap", 250, 255, 100, 0, 1'b0);
        ho_round("sq_during_eval", 10, 10, 200, 0, 1'b1);

        // Non-serving request is ignored.
        rs = m_serving;
        bus.bs_request = 3'b111 & ~3'(1 << rs);
        tick(); tick(); tick();
        chk("foreign_req_valid", 32'(bus.dm_target_valid), 0);
        bus.bs_request = 3'b000;

        // Request and respond drop together: the drop wins.
        bus.bs_request = 3'(1 << rs);
        bus.bs_respond = 3'b000;
        tick();
        bus.bs_request = 3'b000;
        chk("drop_wins_serving", 32'(bus.serving), 3);
        tick();
        chk("drop_wins_valid", 32'(bus.dm_target_valid), 0);
        chk("drop_wins_data_valid", 32'(bus.dm_data_valid), 0);
        chk("drop_wins_dm_sq", 32'(bus.dm_sq), 0);
        bus.bs_respond = 3'b110;
        tick();
        m_serving = 1;
        check_attached("reattach_low");

        for (int i = 0; i < 12; i++)
            ho_round($sformatf("rand%0d", i), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

        // Reset while waiting in HANDOVER.
        load_sq(255, 255, 255);
        load_sq(0, 0, 0);
        m_sq[m_serving] = 0;
        m_sq[(m_serving + 1) % 3] = 200;
        load_sq(m_sq[0], m_sq[1], m_sq[2]);
        bus.bs_request = 3'(1 << m_serving);
        tick(); tick(); tick();
        bus.bs_request = 3'b000;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1 check_reset("reset_in_ho");
        tick();
        reset = 1'b0;
        m_sq = '{0, 0, 0}; m_ok = 0; m_fail = 0;
        bus.bs_respond = 3'b001;
        tick();
        m_serving = 0;
        check_attached("post_reset_attach");
        ho_round("stats_ok", 10, 200, 20, 0, 1'b0);
        ho_round("stats_fail", 10, 20, 200, 1, 1'b0);
`ifdef HO_STATS_EN
        chk("ho_count", 32'(ho_count), m_ok);
        chk("ho_fail_count", 32'(ho_fail_count), m_fail);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
